// File: rtl/linear_pkg.sv
// Shared definitions for the linear row engine.
//   PRECISION_DEF / BIAS_PRECISION_DEF : default operand widths
//   acc_w()                            : full-precision result width
//   state_t                            : engine control states
package linear_pkg;

  localparam int unsigned PRECISION_DEF      = 5;
  localparam int unsigned BIAS_PRECISION_DEF = 32;

  // One guard bit above the wider of the bias and the worst-case dot product,
  // so bias + sum can never overflow.
  function automatic int unsigned acc_w(input int unsigned bias_prec,
                                        input int unsigned prec,
                                        input int unsigned n);
    int unsigned dot_w;
    dot_w = 2 * prec + $clog2(n);
    return ((bias_prec > dot_w) ? bias_prec : dot_w) + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/mac_adder_tree.sv
// Combinational balanced adder tree over N signed products.
//   products : N signed products, each 2*PRECISION bits
//   sum      : signed sum, 2*PRECISION + clog2(N) bits (cannot overflow)
module mac_adder_tree #(
  parameter  int unsigned N         = 5,
  parameter  int unsigned PRECISION = 5,
  localparam int unsigned SUM_W     = 2 * PRECISION + $clog2(N)
) (
  input  logic [N-1:0][2*PRECISION-1:0] products,
  output logic signed [SUM_W-1:0]       sum
);

  localparam int unsigned L = $clog2(N);
  localparam int unsigned P = 1 << L;

  // Level 0 holds the sign-extended leaves padded with zeros up to a power of
  // two; each further level halves the node count.
  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int unsigned CNT = P >> l;
    logic signed [SUM_W-1:0] v [CNT];
    for (genvar k = 0; k < CNT; k++) begin : g_node
      if (l == 0) begin : g_leaf
        if (k < N) begin : g_used
          assign v[k] = SUM_W'($signed(products[k]));
        end else begin : g_pad
          assign v[k] = '0;
        end
      end else begin : g_add
        assign v[k] = g_lvl[l-1].v[2*k] + g_lvl[l-1].v[2*k+1];
      end
    end
  end

  assign sum = g_lvl[L].v[0];

endmodule

// File: rtl/linear_row_engine.sv
// Linear layer row engine: y[m] = bias[m] + sum_i(w[m][i] * x[i]).
//   clk, rst         : clock, synchronous active-high reset
//   x_valid/x_ready  : activation vector handshake (taken only in IDLE)
//   x_data           : N signed activations
//   w_valid/w_ready  : weight row + bias handshake (w_ready feeds fetcher ce)
//   w_data, bias     : N signed weights and signed bias of the row
//   y_valid/y_ready  : result handshake
//   y_data           : signed full-precision result
//   y_idx, y_last    : row index of the result, high on row M-1
//   busy             : engine not IDLE
module linear_row_engine
  import linear_pkg::*;
#(
  parameter  int unsigned M              = 5,
  parameter  int unsigned N              = 5,
  parameter  int unsigned PRECISION      = PRECISION_DEF,
  parameter  int unsigned BIAS_PRECISION = BIAS_PRECISION_DEF,
  localparam int unsigned ACC_W          = acc_w(BIAS_PRECISION, PRECISION, N),
  localparam int unsigned SUM_W          = 2 * PRECISION + $clog2(N),
  localparam int unsigned IDX_W          = (M > 1) ? $clog2(M) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              x_valid,
  output logic                              x_ready,
  input  logic [N-1:0][PRECISION-1:0]       x_data,
  input  logic                              w_valid,
  output logic                              w_ready,
  input  logic [N-1:0][PRECISION-1:0]       w_data,
  input  logic signed [BIAS_PRECISION-1:0]  bias,
  output logic                              y_valid,
  input  logic                              y_ready,
  output logic signed [ACC_W-1:0]           y_data,
  output logic [IDX_W-1:0]                  y_idx,
  output logic                              y_last,
  output logic                              busy
);

  state_t                              state;
  logic [IDX_W-1:0]                    row_cnt;
  logic [N-1:0][PRECISION-1:0]         x_lat;

  logic                                s1_valid;
  logic [N-1:0][2*PRECISION-1:0]       s1_prod;
  logic signed [BIAS_PRECISION-1:0]    s1_bias;
  logic [IDX_W-1:0]                    s1_idx;

  logic                                s2_valid;
  logic signed [SUM_W-1:0]             s2_sum;
  logic signed [BIAS_PRECISION-1:0]    s2_bias;
  logic [IDX_W-1:0]                    s2_idx;

  logic [N-1:0][2*PRECISION-1:0]       prod_c;
  logic signed [SUM_W-1:0]             tree_sum;
  logic                                adv;
  logic                                accept;

  // Single global enable: a stalled output freezes every stage, so the input
  // must stop in the same cycle or a row would be lost.
  assign adv     = !y_valid || y_ready;
  assign w_ready = (state == RUN) && adv;
  assign accept  = w_valid && w_ready;
  assign x_ready = (state == IDLE);
  assign busy    = (state != IDLE);

  always_comb begin
    prod_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      prod_c[i] = (2*PRECISION)'($signed(w_data[i])) *
                  (2*PRECISION)'($signed(x_lat[i]));
    end
  end

  mac_adder_tree #(
    .N         (N),
    .PRECISION (PRECISION)
  ) u_tree (
    .products (s1_prod),
    .sum      (tree_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      row_cnt  <= '0;
      x_lat    <= '0;
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_bias  <= '0;
      s1_idx   <= '0;
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_bias  <= '0;
      s2_idx   <= '0;
      y_valid  <= 1'b0;
      y_data   <= '0;
      y_idx    <= '0;
      y_last   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (x_valid) begin
            x_lat   <= x_data;
            row_cnt <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (row_cnt == IDX_W'(M - 1)) begin
              row_cnt <= '0;
              state   <= DRAIN;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (y_valid && y_ready && y_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_prod <= prod_c;
          s1_bias <= bias;
          s1_idx  <= row_cnt;
        end
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_sum  <= tree_sum;
          s2_bias <= s1_bias;
          s2_idx  <= s1_idx;
        end
        y_valid <= s2_valid;
        if (s2_valid) begin
          y_data <= ACC_W'(s2_sum) + ACC_W'(s2_bias);
          y_idx  <= s2_idx;
          y_last <= (s2_idx == IDX_W'(M - 1));
        end
      end
    end
  end

endmodule

// File: tb/tb_linear_row_engine.sv
module tb_linear_row_engine;

  localparam int unsigned M  = 3;
  localparam int unsigned N  = 4;
  localparam int unsigned PR = 8;
  localparam int unsigned BP = 32;
  localparam int unsigned AW = 33;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    x_valid;
  logic                    x_ready;
  logic [N-1:0][PR-1:0]    x_data;
  logic                    w_valid;
  logic                    w_ready;
  logic [N-1:0][PR-1:0]    w_data;
  logic signed [BP-1:0]    bias;
  logic                    y_valid;
  logic                    y_ready;
  logic signed [AW-1:0]    y_data;
  logic [1:0]              y_idx;
  logic                    y_last;
  logic                    busy;

  linear_row_engine #(
    .M              (M),
    .N              (N),
    .PRECISION      (PR),
    .BIAS_PRECISION (BP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .x_data  (x_data),
    .w_valid (w_valid),
    .w_ready (w_ready),
    .w_data  (w_data),
    .bias    (bias),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_data  (y_data),
    .y_idx   (y_idx),
    .y_last  (y_last),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic last_acc;
  int zeros;

  logic signed [AW-1:0] rd[$];
  logic [1:0]           ri[$];
  logic                 rl[$];
  int                   rc[$];
  int                   ac[$];

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic clear_q();
    rd.delete(); ri.delete(); rl.delete(); rc.delete(); ac.delete();
  endtask

  // Samples handshakes just before the edge, then advances one cycle.
  task automatic tick();
    #1;
    last_acc = w_valid && w_ready;
    if (last_acc) ac.push_back(cyc);
    if (y_valid && y_ready) begin
      rd.push_back(y_data);
      ri.push_back(y_idx);
      rl.push_back(y_last);
      rc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_row(input string tag, input logic [31:0] wd, input int b);
    w_valid = 1'b1;
    w_data  = wd;
    bias    = b;
    last_acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (last_acc) break;
    end
    w_valid = 1'b0;
    chk(tag, last_acc, 1);
  endtask

  task automatic start_x(input logic [31:0] xd);
    x_valid = 1'b1;
    x_data  = xd;
    tick();
    x_valid = 1'b0;
  endtask

  task automatic wait_results(input string tag, input int n);
    for (int i = 0; i < 40 && rd.size() < n; i++) tick();
    chk(tag, rd.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && busy !== 1'b0; i++) tick();
    chk(tag, busy, 0);
  endtask

  task automatic send_std_rows(input string tag);
    send_row({tag, "_r0"}, pk(1, 1, 1, 1), 10);
    send_row({tag, "_r1"}, pk(0, 0, 0, 2), -1);
    send_row({tag, "_r2"}, pk(-1, 0, 0, 0), 0);
  endtask

  task automatic chk_std_results(input string tag, input int e0, input int e1, input int e2);
    chk({tag, "_y0"}, rd[0], e0);
    chk({tag, "_y1"}, rd[1], e1);
    chk({tag, "_y2"}, rd[2], e2);
    chk({tag, "_i0"}, ri[0], 0);
    chk({tag, "_i1"}, ri[1], 1);
    chk({tag, "_i2"}, ri[2], 2);
    chk({tag, "_l0"}, rl[0], 0);
    chk({tag, "_l1"}, rl[1], 0);
    chk({tag, "_l2"}, rl[2], 1);
  endtask

  initial begin
    rst = 1'b1; x_valid = 1'b0; x_data = '0; w_valid = 1'b0; w_data = '0;
    bias = '0; y_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_data",  y_data, 0);
    chk("rst_y_idx",   y_idx, 0);
    chk("rst_y_last",  y_last, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_x_ready", x_ready, 1);
    chk("rst_busy",    busy, 0);

    // Basic inference, then x_data disturbed after the latch.
    clear_q();
    start_x(pk(1, 2, 3, 4));
    chk("run_busy",    busy, 1);
    chk("run_x_ready", x_ready, 0);
    x_data = pk(9, 9, 9, 9);
    send_std_rows("basic");
    wait_results("basic_cnt", 3);
    chk_std_results("basic", 20, 7, -1);
    chk("basic_latency", rc[0] - ac[0], 3);
    wait_idle("basic_idle");

    // Extreme operands.
    clear_q();
    start_x(pk(-128, -128, -128, -128));
    send_row("ext_r0", pk(-128, -128, -128, -128), 0);
    send_row("ext_r1", pk(127, 127, 127, 127), 32'h8000_0000);
    send_row("ext_r2", pk(0, 0, 0, 0), 0);
    wait_results("ext_cnt", 3);
    chk("ext_y0", rd[0], 65536);
    chk("ext_y1", rd[1], -64'sd2147548672);
    chk("ext_y2", rd[2], 0);
    chk("ext_l2", rl[2], 1);
    wait_idle("ext_idle");

    // Output stall of 5 cycles with row 2 waiting.
    clear_q();
    start_x(pk(1, 2, 3, 4));
    send_row("stall_r0", pk(1, 1, 1, 1), 10);
    send_row("stall_r1", pk(0, 0, 0, 2), -1);
    tick();
    y_ready = 1'b0;
    w_valid = 1'b1; w_data = pk(-1, 0, 0, 0); bias = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_w_ready", w_ready, 0);
      chk("stall_y_valid", y_valid, 1);
      chk("stall_y_data",  y_data, 20);
      chk("stall_y_idx",   y_idx, 0);
      tick();
    end
    y_ready = 1'b1;
    send_row("stall_r2", pk(-1, 0, 0, 0), 0);
    wait_results("stall_cnt", 3);
    chk_std_results("stall", 20, 7, -1);
    wait_idle("stall_idle");

    // Reset in the middle of an inference.
    clear_q();
    start_x(pk(1, 2, 3, 4));
    send_row("mid_r0", pk(1, 1, 1, 1), 10);
    send_row("mid_r1", pk(0, 0, 0, 2), -1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_y_valid", y_valid, 0);
    chk("mid_busy",    busy, 0);
    chk("mid_x_ready", x_ready, 1);
    clear_q();
    start_x(pk(1, 2, 3, 4));
    send_std_rows("after");
    wait_results("after_cnt", 3);
    for (int i = 0; i < 6; i++) tick();
    chk("after_cnt_final", rd.size(), 3);
    chk_std_results("after", 20, 7, -1);
    wait_idle("after_idle");

    // Back-to-back inferences with x_valid held high.
    clear_q();
    x_valid = 1'b1;
    x_data  = pk(1, 2, 3, 4);
    tick();
    x_data  = pk(2, 2, 2, 2);
    send_std_rows("b2b1");
    zeros = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy === 1'b0) zeros++;
    end
    chk("b2b_busy_gap", zeros, 1);
    chk("b2b1_cnt", rd.size(), 3);
    chk_std_results("b2b1", 20, 7, -1);
    clear_q();
    send_std_rows("b2b2");
    x_valid = 1'b0;
    wait_results("b2b2_cnt", 3);
    chk_std_results("b2b2", 18, 3, -2);
    wait_idle("b2b2_idle");

    // Rows offered every other cycle.
    clear_q();
    start_x(pk(1, 2, 3, 4));
    send_row("tog_r0", pk(1, 1, 1, 1), 10);
    tick();
    send_row("tog_r1", pk(0, 0, 0, 2), -1);
    tick();
    send_row("tog_r2", pk(-1, 0, 0, 0), 0);
    wait_results("tog_cnt", 3);
    chk_std_results("tog", 20, 7, -1);
    chk("tog_gap01", rc[1] - rc[0], ac[1] - ac[0]);
    chk("tog_gap12", rc[2] - rc[1], ac[2] - ac[1]);
    chk("tog_acc_gap", ac[1] - ac[0], 2);
    wait_idle("tog_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
